// File: rtl/anim_pkg.sv
// Shared LED animation definitions: frame width, fader state and the PWM duty curve.
// LED_FADER_GAMMA_EN selects a squared (gamma) duty curve instead of the linear one.
package anim_pkg;

    localparam int LED_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        FADE = 1'b1
    } state_t;

    // Result is masked to pwm_bits+1 bits; x ranges 0..2^pwm_bits.
    function automatic logic [15:0] duty(input logic [15:0] x, input int pwm_bits);
        logic [15:0] mask;
`ifdef LED_FADER_GAMMA_EN
        logic [31:0] sq;
        mask = (16'd2 << pwm_bits) - 16'd1;
        sq   = 32'(x) * 32'(x);
        return 16'(sq >> pwm_bits) & mask;
`else
        mask = (16'd2 << pwm_bits) - 16'd1;
        return x & mask;
`endif
    endfunction

endpackage

// File: rtl/led_pwm_bit.sv
// Per-LED output decision: steady when the bit does not change, otherwise
// a PWM comparison against the fade-in or fade-out duty.
module led_pwm_bit
    import anim_pkg::*;
#(
    parameter int PWM_BITS = 4
) (
    input  logic                old_bit,
    input  logic                tgt_bit,
    input  state_t              state,
    input  logic [PWM_BITS:0]   duty_in,
    input  logic [PWM_BITS:0]   duty_out,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led_next
);

    always_comb begin
        led_next = tgt_bit;
        if (state == FADE && old_bit != tgt_bit) begin
            if (tgt_bit)
                led_next = ({1'b0, pwm_cnt} < duty_in);
            else
                led_next = ({1'b0, pwm_cnt} < duty_out);
        end
    end

endmodule

// File: rtl/led_fader.sv
// LED output stage: crossfades changed bits with PWM over 2^PWM_BITS levels.
// Build option: LED_FADER_GAMMA_EN switches the duty curve to gamma (see anim_pkg).
module led_fader
    import anim_pkg::*;
#(
    parameter int LED_W       = anim_pkg::LED_W,
    parameter int PWM_BITS    = 4,
    parameter int STEP_CYCLES = 65536
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LED_W-1:0] frame_in,
    output logic [LED_W-1:0] led_out,
    output logic             busy,
    output state_t           state_dbg
);

    localparam int DW  = PWM_BITS + 1;
    localparam int MAX = 1 << PWM_BITS;
    localparam int SW  = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [DW-1:0] K_MAX     = DW'(MAX);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

    state_t              state, state_n;
    logic [LED_W-1:0]    tgt, tgt_n, old, old_n, led_next;
    logic [DW-1:0]       k, k_n, duty_in, duty_out;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [SW-1:0]       step_cnt, step_n;
    logic                busy_n;

    assign state_dbg = state;
    assign duty_in   = DW'(duty(16'(k), PWM_BITS));
    assign duty_out  = DW'(duty(16'(K_MAX - k), PWM_BITS));

    always_comb begin
        state_n = state;
        tgt_n   = tgt;
        old_n   = old;
        k_n     = k;
        step_n  = step_cnt;
        busy_n  = busy;
        // A frame change always (re)starts the fade, even on the final step edge.
        if (frame_in != tgt) begin
            old_n   = tgt;
            tgt_n   = frame_in;
            k_n     = '0;
            step_n  = '0;
            state_n = FADE;
            busy_n  = 1'b1;
        end else begin
            case (state)
                IDLE: busy_n = 1'b0;
                FADE: begin
                    if (step_cnt == STEP_LAST) begin
                        step_n = '0;
                        if (k == K_MAX - DW'(1)) begin
                            k_n     = K_MAX;
                            state_n = IDLE;
                            busy_n  = 1'b0;
                        end else begin
                            k_n = k + DW'(1);
                        end
                    end else begin
                        step_n = step_cnt + SW'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tgt      <= '0;
            old      <= '0;
            k        <= '0;
            pwm_cnt  <= '0;
            step_cnt <= '0;
            led_out  <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            tgt      <= tgt_n;
            old      <= old_n;
            k        <= k_n;
            pwm_cnt  <= pwm_cnt + PWM_BITS'(1);
            step_cnt <= step_n;
            led_out  <= led_next;
            busy     <= busy_n;
        end
    end

    for (genvar i = 0; i < LED_W; i++) begin : g_bit
        led_pwm_bit #(.PWM_BITS(PWM_BITS)) u_bit (
            .old_bit  (old[i]),
            .tgt_bit  (tgt[i]),
            .state    (state),
            .duty_in  (duty_in),
            .duty_out (duty_out),
            .pwm_cnt  (pwm_cnt),
            .led_next (led_next[i])
        );
    end

endmodule

// File: tb/tb_led_fader.sv
// Directed bench for led_fader (PWM_BITS=2, STEP_CYCLES=4): expectations are queued
// with absolute sample cycles and checked by an independent negedge monitor.
module tb_led_fader;
    import anim_pkg::*;

    localparam int K_CNT  = 0;
    localparam int K_BUSY = 1;
    localparam int K_LED  = 2;
    localparam int K_ST   = 3;

    typedef struct {
        string       name;
        int          kind;
        int          c0;
        int          n;
        int          bitn;
        logic [15:0] val;
        int          exp;
        int          acc;
        logic [15:0] act;
    } item_t;

    logic        clk;
    logic        rst;
    logic [15:0] frame_in;
    logic [15:0] led_out;
    logic        busy;
    state_t      state_dbg;

    int    cyc = 0;
    int    tests_run = 0;
    int    fails = 0;
    item_t exp_q[$];
    int    fin [4];
    int    fout [4];

    led_fader #(.LED_W(16), .PWM_BITS(2), .STEP_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .frame_in  (frame_in),
        .led_out   (led_out),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // Clock and cycle stamp (cyc = number of rising edges so far).
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Driver helpers.
    task automatic push(input string nm, input int kind, input int c0, input int n,
                        input int b, input logic [15:0] v, input int e);
        item_t it;
        it.name = nm; it.kind = kind; it.c0 = c0; it.n = n; it.bitn = b;
        it.val = v; it.exp = e; it.acc = 0; it.act = '0;
        exp_q.push_back(it);
    endtask

    task automatic push_fade(input string nm, input int n0, input int b, input int tab [4]);
        for (int j = 0; j < 4; j++)
            push($sformatf("%s_w%0d", nm, j), K_CNT, n0 + 1 + 4 * j, 4, b, '0, tab[j]);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic set_frame(input logic [15:0] v, output int n);
        frame_in = v;
        n = cyc + 1;
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        item_t it;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (cyc >= exp_q[i].c0 && cyc < exp_q[i].c0 + exp_q[i].n) begin
                case (exp_q[i].kind)
                    K_CNT:  exp_q[i].acc += int'(led_out[exp_q[i].bitn]);
                    K_BUSY: exp_q[i].acc += int'(busy);
                    K_LED:  exp_q[i].act = led_out;
                    default: exp_q[i].act = 16'(state_dbg);
                endcase
            end
        end
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (cyc >= exp_q[i].c0 + exp_q[i].n - 1) begin
                it = exp_q[i];
                tests_run++;
                if (it.kind == K_LED || it.kind == K_ST) begin
                    if (it.act !== it.val) begin
                        fails++;
                        $display("FAIL %s: got 16'h%04h, expected 16'h%04h", it.name, it.act, it.val);
                    end
                end else if (it.acc != it.exp) begin
                    fails++;
                    $display("FAIL %s: got count %0d, expected %0d", it.name, it.acc, it.exp);
                end
                exp_q.delete(i);
            end
        end
    end

    initial begin
        int n, n1, n2;
`ifdef LED_FADER_GAMMA_EN
        fin  = '{0, 0, 1, 2};
        fout = '{4, 2, 1, 0};
`else
        fin  = '{0, 1, 2, 3};
        fout = '{4, 3, 2, 1};
`endif
        rst = 1'b1;
        frame_in = 16'hFFFF;
        #1 rst = 1'b0;

        // Reset held with a non-zero frame, then release starts a fade from all-off.
        @(negedge clk);
        push("rst_led", K_LED, cyc + 1, 1, 0, 16'h0000, 0);
        push("rst_busy", K_BUSY, cyc + 1, 3, 0, '0, 0);
        wait_cyc(5);
        rst = 1'b1;
        n = cyc + 1;
        push("rel_busy_on", K_BUSY, n, 16, 0, '0, 16);
        push("rel_busy_off", K_BUSY, n + 16, 1, 0, '0, 0);
        push_fade("rel_b0", n, 0, fin);
        push("rel_led", K_LED, n + 17, 1, 0, 16'hFFFF, 0);
        wait_cyc(n + 17);

        // Fade-in of bit 0 from all-off.
        set_frame(16'h0000, n);
        wait_cyc(n + 17);
        set_frame(16'h0001, n);
        push_fade("fin_b0", n, 0, fin);
        push("fin_b1", K_CNT, n + 1, 16, 1, '0, 0);
        push("fin_b15", K_CNT, n + 1, 16, 15, '0, 0);
        push("fin_led", K_LED, n + 17, 1, 0, 16'h0001, 0);
        push("fin_steady", K_CNT, n + 17, 4, 0, '0, 4);
        wait_cyc(n + 21);

        // Swap halves: every bit changes.
        set_frame(16'h00FF, n);
        wait_cyc(n + 17);
        set_frame(16'hFF00, n);
        push_fade("swap_b0", n, 0, fout);
        push_fade("swap_b7", n, 7, fout);
        push_fade("swap_b8", n, 8, fin);
        push_fade("swap_b15", n, 15, fin);
        push("swap_busy", K_BUSY, n, 16, 0, '0, 16);
        push("swap_idle", K_BUSY, n + 16, 1, 0, '0, 0);
        push("swap_st_fade", K_ST, n + 1, 1, 0, 16'(FADE), 0);
        push("swap_st_idle", K_ST, n + 16, 1, 0, 16'(IDLE), 0);
        push("swap_led", K_LED, n + 17, 1, 0, 16'hFF00, 0);
        wait_cyc(n + 17);

        // Restart six cycles into a fade; old snaps to 16'h000F.
        set_frame(16'h000F, n1);
        push("rs_busy", K_BUSY, n1, 22, 0, '0, 22);
        push("rs_idle", K_BUSY, n1 + 22, 1, 0, '0, 0);
        wait_cyc(n1 + 5);
        set_frame(16'h00F0, n2);
        push_fade("rs_b0", n2, 0, fout);
        push_fade("rs_b4", n2, 4, fin);
        push("rs_b8", K_CNT, n2 + 1, 16, 8, '0, 0);
        push("rs_led", K_LED, n2 + 17, 1, 0, 16'h00F0, 0);
        wait_cyc(n2 + 17);

        // Asynchronous reset five cycles into a fade.
        set_frame(16'h0F0F, n);
        push("rmf_pre_led", K_LED, n + 4, 1, 0, 16'h00F0, 0);
        push("rmf_pre_busy", K_BUSY, n, 5, 0, '0, 5);
        wait_cyc(n + 4);
        @(posedge clk);
        #1 rst = 1'b0;
        push("rmf_led", K_LED, n + 5, 1, 0, 16'h0000, 0);
        push("rmf_busy", K_BUSY, n + 5, 1, 0, '0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        n = cyc + 1;
        push_fade("post_b0", n, 0, fin);
        push("post_b4", K_CNT, n + 1, 16, 4, '0, 0);
        push("post_busy", K_BUSY, n, 16, 0, '0, 16);
        push("post_led", K_LED, n + 17, 1, 0, 16'h0F0F, 0);
        wait_cyc(n + 18);

        for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clk);
        while (exp_q.size() > 0) begin
            tests_run++;
            fails++;
            $display("FAIL %s: window never completed, expected %0d", exp_q[0].name, exp_q[0].exp);
            void'(exp_q.pop_front());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
